lsu_mem_port: RTL and testbench

Parametrised data-memory port for the store/load stage of base_pipeline. It generalises the word-only store path to the full RV32I size set: SB/SH/SW stores and LB/LH/LW/LBU/LHU loads. It generates byte enables, aligns and sign-extends load data, and flags misaligned, out-of-range and illegal-size accesses. An optional reset-time clear sequencer zeroes the array and raises busy so the pipeline stalls.

---
 rtl/lsu_mem_port_pkg.sv | 79 +++++++
 rtl/lsu_mem_port_if.sv | 24 ++
 rtl/lsu_mem_port_ram_be_array.sv | 38 +++
 rtl/lsu_mem_port.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared memory-op encodings and decode helpers for the load/store data port.
// Size fields follow the RISC-V funct3 encoding of loads and stores.
package lsu_mem_port_pkg;

    localparam logic [2:0] MEM_F3_B  = 3'b000;
    localparam logic [2:0] MEM_F3_H  = 3'b001;
    localparam logic [2:0] MEM_F3_W  = 3'b010;
    localparam logic [2:0] MEM_F3_BU = 3'b100;
    localparam logic [2:0] MEM_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_FAULT_NONE  = 2'd0,
        LSU_FAULT_RANGE = 2'd1,
        LSU_FAULT_SIZE  = 2'd2
    } lsu_fault_e;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic logic size_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            MEM_F3_B, MEM_F3_H, MEM_F3_W: ok = 1'b1;
            MEM_F3_BU, MEM_F3_HU:         ok = ~is_store;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{din[7:0]}};
            2'b01:   d = {2{din[15:0]}};
            default: d = din;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lo, 3'b000};
        case (f3)
            MEM_F3_B:  r = {{24{sh[7]}}, sh[7:0]};
            MEM_F3_H:  r = {{16{sh[15]}}, sh[15:0]};
            MEM_F3_W:  r = word;
            MEM_F3_BU: r = {24'd0, sh[7:0]};
            MEM_F3_HU: r = {16'd0, sh[15:0]};
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response bundle between the pipeline store/load stage and the data port.
interface lsu_mem_port_if;
    logic        en;
    logic        we;
    logic        re;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        misaligned;
    logic        fault;
    logic        busy;

    modport master (
        output en, we, re, funct3, addr, din,
        input  dout, dout_valid, misaligned, fault, busy
    );

    modport slave (
        input  en, we, re, funct3, addr, din,
        output dout, dout_valid, misaligned, fault, busy
    );
endinterface

// File: rtl/lsu_mem_port_ram_be_array.sv
// Single-port synchronous 32-bit RAM with per-byte write enables.
// The data array is left visible by name so the bench can inspect it.
module ram_be_array
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS),
    parameter              INIT_FILE   = ""
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] idx_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] data [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // byte-lane write and registered read share one port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    data[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= data[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_port.sv
// Data-memory port: size/alignment/range decode, byte-lane stores, extending
// loads with one cycle of latency, and an optional post-reset array clear.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter              INIT_FILE      = ""
) (
    input  logic           clk_i,
    input  logic           rst_i,
    lsu_mem_port_if.slave  bus
);

    localparam int unsigned    AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]    SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [AW-1:0]  CNT_ONE  = AW'(1'b1);
    localparam logic [AW-1:0]  CNT_LAST = AW'(DEPTH_WORDS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          clr_we_s;
    logic          busy_s;

    logic [32:0]   diff_s;
    logic          is_load_s, accept_s, legal_s, mis_s, access_s;
    lsu_fault_e    cause_s;

    logic          ram_we_s, ram_re_s;
    logic [AW-1:0] ram_idx_s;
    logic [3:0]    ram_be_s;
    logic [31:0]   ram_wdata_s, ram_rdata_s;

    logic          valid_q, mis_q, fault_q;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;
    logic [31:0]   dout_s;

    // clear sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR_ON_RESET ? CLR_CLEAR : CLR_IDLE;
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear sequencer next state: one word zeroed per cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_s = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                state_d = CLR_IDLE;
            end
            CLR_CLEAR: begin
                clr_we_s = 1'b1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_IDLE;
                end else begin
                    state_d = CLR_CLEAR;
                end
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    assign busy_s = (state_q == CLR_CLEAR);

    // request decode; a borrow out of the subtraction also lands out of range
    always_comb begin
        diff_s    = {1'b0, bus.addr} - {1'b0, ADDR_BASE};
        is_load_s = bus.re & ~bus.we;
        accept_s  = bus.en & ~rst_i & ~busy_s & (bus.we | bus.re);
        legal_s   = size_legal(bus.we, bus.funct3);
        // alignment only has a meaning once the size itself is legal
        mis_s     = legal_s & is_misaligned(bus.funct3[1:0], bus.addr[1:0]);
        if (!legal_s) begin
            cause_s = LSU_FAULT_SIZE;
        end else if (diff_s >= SPAN) begin
            cause_s = LSU_FAULT_RANGE;
        end else begin
            cause_s = LSU_FAULT_NONE;
        end
        access_s  = accept_s & ~mis_s & (cause_s == LSU_FAULT_NONE);
    end

    // single RAM port shared by the clear sequencer and pipeline accesses
    always_comb begin
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_idx_s   = diff_s[AW+1:2];
        ram_be_s    = 4'b0000;
        ram_wdata_s = 32'd0;
        if (busy_s) begin
            ram_we_s  = clr_we_s & ~rst_i;
            ram_idx_s = cnt_q;
            ram_be_s  = 4'b1111;
        end else if (access_s) begin
            ram_we_s    = bus.we;
            ram_re_s    = is_load_s;
            ram_be_s    = store_be(bus.funct3[1:0], bus.addr[1:0]);
            ram_wdata_s = store_data(bus.funct3[1:0], bus.din);
        end else begin
            ram_we_s = 1'b0;
        end
    end

    ram_be_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_s),
        .re_i    (ram_re_s),
        .idx_i   (ram_idx_s),
        .be_i    (ram_be_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // response slot: flags and load context, frozen while the stage stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
        end else if (bus.en) begin
            valid_q <= access_s & is_load_s;
            mis_q   <= accept_s & mis_s;
            fault_q <= accept_s & (cause_s != LSU_FAULT_NONE);
            f3_q    <= bus.funct3;
            lo_q    <= bus.addr[1:0];
        end
    end

    // load alignment and extension from the registered read word
    always_comb begin
        if (valid_q) begin
            dout_s = load_extract(f3_q, lo_q, ram_rdata_s);
        end else begin
            dout_s = 32'd0;
        end
    end

    assign bus.dout       = dout_s;
    assign bus.dout_valid = valid_q;
    assign bus.misaligned = mis_q;
    assign bus.fault      = fault_q;
    assign bus.busy       = busy_s;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised and directed bench for lsu_mem_port against a byte-level memory model.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_mem_port_if bus();

    lsu_mem_port #(
        .DEPTH_WORDS    (DW),
        .ADDR_BASE      (32'h0000_0000),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors  = 0;
    int errors   = 0;
    bit check_en = 1'b0;

    bit [31:0] mem_m [DW];
    int        clr_left = 0;
    bit        exp_valid = 1'b0, exp_mis = 1'b0, exp_fault = 1'b0;
    bit [31:0] exp_dout = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one accepted request, in byte terms.
    task automatic model_access(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        int        size;
        int        lane;
        bit        legal;
        bit [31:0] w;
        size  = 1 << f3[1:0];
        legal = (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
        exp_fault = !legal || (a >= 32'(4 * DW));
        exp_mis   = legal && ((a % size) != 0);
        if (exp_fault || exp_mis) return;
        if (st) begin
            for (int k = 0; k < size; k++) begin
                lane = int'(a % 4) + k;
                mem_m[a / 4][8*lane +: 8] = d[8*k +: 8];
            end
        end else begin
            w = mem_m[a / 4] >> (8 * (a % 4));
            if (size == 1)      exp_dout = f3[2] ? (w & 32'h0000_00FF) : 32'($signed(w[7:0]));
            else if (size == 2) exp_dout = f3[2] ? (w & 32'h0000_FFFF) : 32'($signed(w[15:0]));
            else                exp_dout = w;
            exp_valid = 1'b1;
        end
    endtask

    // model advances on every clock edge from the bench-driven inputs
    always @(posedge clk) begin
        if (rst) begin
            exp_valid = 1'b0; exp_mis = 1'b0; exp_fault = 1'b0; exp_dout = 32'd0;
            clr_left  = DW;
        end else if (clr_left > 0) begin
            mem_m[DW - clr_left] = 32'd0;
            clr_left--;
            exp_valid = 1'b0; exp_mis = 1'b0; exp_fault = 1'b0; exp_dout = 32'd0;
        end else if (bus.en) begin
            exp_valid = 1'b0; exp_mis = 1'b0; exp_fault = 1'b0; exp_dout = 32'd0;
            if (bus.we || bus.re) model_access(bus.we, bus.funct3, bus.addr, bus.din);
        end
    end

    // single compare point, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("dout",       bus.dout,       exp_dout);
            chk("dout_valid", bus.dout_valid, exp_valid);
            chk("misaligned", bus.misaligned, exp_mis);
            chk("fault",      bus.fault,      exp_fault);
            chk("busy",       bus.busy,       (clr_left > 0));
        end
    end

    task automatic drive(input bit e, input bit w, input bit r, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] d);
        bus.en = e; bus.we = w; bus.re = r; bus.funct3 = f3; bus.addr = a; bus.din = d;
    endtask

    task automatic op(input bit w, input bit r, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
        drive(1'b1, w, r, f3, a, d);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!bus.busy) break;
            n++;
            @(negedge clk);
        end
        chk("busy_timeout", bus.busy, 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int        n;
        logic [31:0] keep;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_en = 1'b1;
        chk("reset_dout", bus.dout, 32'd0);
        chk("reset_busy", bus.busy, 32'd1);
        rst = 1'b0;
        count_busy(n);
        chk("busy_len_powerup", n, 32'd16);

        // fill with ones, then reset-clear with a store issued while busy
        for (int i = 0; i < DW; i++) op(1'b1, 1'b0, MEM_F3_W, 32'(4 * i), 32'hFFFF_FFFF);
        chk("prefill", dut.u_ram.data[5], 32'hFFFF_FFFF);
        pulse_rst();
        drive(1'b1, 1'b1, 1'b0, MEM_F3_W, 32'd0, 32'h1234_5678);
        count_busy(n);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("busy_len_clear", n, 32'd16);
        for (int i = 0; i < DW; i++) chk("cleared_word", dut.u_ram.data[i], 32'd0);

        // reset again five cycles into a clear
        pulse_rst();
        repeat (5) @(negedge clk);
        pulse_rst();
        count_busy(n);
        chk("busy_len_restart", n, 32'd16);

        op(1'b1, 1'b0, MEM_F3_W, 32'd4, 32'h0102_0304);
        op(1'b0, 1'b1, MEM_F3_B, 32'd5, 32'd0);
        chk("lb5_dout", bus.dout, 32'h0000_0003);
        chk("lb5_valid", bus.dout_valid, 32'd1);
        op(1'b0, 1'b1, MEM_F3_W, 32'd4, 32'd0);
        chk("lw4", bus.dout, 32'h0102_0304);

        op(1'b1, 1'b0, MEM_F3_B, 32'd8, 32'h0000_0080);
        op(1'b0, 1'b1, MEM_F3_B, 32'd8, 32'd0);
        chk("lb8", bus.dout, 32'hFFFF_FF80);
        op(1'b0, 1'b1, MEM_F3_BU, 32'd8, 32'd0);
        chk("lbu8", bus.dout, 32'h0000_0080);
        op(1'b0, 1'b1, MEM_F3_H, 32'd8, 32'd0);
        chk("lh8", bus.dout, 32'h0000_0080);

        op(1'b1, 1'b0, MEM_F3_H, 32'd6, 32'h0000_BEEF);
        op(1'b0, 1'b1, MEM_F3_W, 32'd4, 32'd0);
        chk("lw4_after_sh", bus.dout, 32'hBEEF_0304);
        op(1'b0, 1'b1, MEM_F3_HU, 32'd6, 32'd0);
        chk("lhu6", bus.dout, 32'h0000_BEEF);
        op(1'b0, 1'b1, MEM_F3_H, 32'd6, 32'd0);
        chk("lh6", bus.dout, 32'hFFFF_BEEF);

        op(1'b1, 1'b0, MEM_F3_W, 32'd2, 32'hAAAA_5555);
        chk("sw2_mis", bus.misaligned, 32'd1);
        chk("sw2_fault", bus.fault, 32'd0);
        chk("sw2_data0", dut.u_ram.data[0], 32'd0);
        op(1'b0, 1'b1, MEM_F3_H, 32'd3, 32'd0);
        chk("lh3_mis", bus.misaligned, 32'd1);
        chk("lh3_valid", bus.dout_valid, 32'd0);
        op(1'b1, 1'b0, MEM_F3_BU, 32'd8, 32'h0000_0011);
        chk("sbu_fault", bus.fault, 32'd1);
        op(1'b0, 1'b1, MEM_F3_W, 32'd64, 32'd0);
        chk("lw64_fault", bus.fault, 32'd1);
        chk("lw64_dout", bus.dout, 32'd0);
        op(1'b1, 1'b1, MEM_F3_W, 32'd12, 32'hCAFE_F00D);
        chk("we_re_valid", bus.dout_valid, 32'd0);
        chk("we_re_data3", dut.u_ram.data[3], 32'hCAFE_F00D);

        // stall three cycles with a store pending on the inputs
        op(1'b0, 1'b1, MEM_F3_W, 32'd4, 32'd0);
        keep = dut.u_ram.data[0];
        drive(1'b0, 1'b1, 1'b0, MEM_F3_W, 32'd0, 32'h5A5A_5A5A);
        repeat (3) begin
            @(negedge clk);
            chk("stall_dout", bus.dout, 32'hBEEF_0304);
            chk("stall_valid", bus.dout_valid, 32'd1);
        end
        chk("stall_no_write", dut.u_ram.data[0], keep);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        for (int i = 0; i < 800; i++) begin
            bit [2:0]  f3;
            bit [31:0] a;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
            a  = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            drive($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  f3, a, $urandom);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        count_busy(n);
        for (int i = 0; i < DW; i++) chk("final_word", dut.u_ram.data[i], mem_m[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
